// File: rtl/pixel_proc_stream.sv
// Streaming pixel processor: bypass / invert / signed 3x3 convolution / threshold, per-frame config.
// Optional clamp counter output sat_cnt enabled by defining PIX_PROC_SAT_CNT_EN.
module pixel_proc_stream #(
  parameter int PIX_W    = 8,
  parameter int MAX_LINE = 1024,
  parameter int LEN_W    = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PIX_W-1:0]  s_pixel,
  input  logic              s_sof,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [1:0]        mode,
  input  logic [71:0]       kernel,
  input  logic [3:0]        norm_shift,
  input  logic [PIX_W-1:0]  thresh,
  input  logic [LEN_W-1:0]  line_len,
  output logic [PIX_W-1:0]  m_pixel,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy
`ifdef PIX_PROC_SAT_CNT_EN
  ,output logic [15:0]      sat_cnt
`endif
);

  localparam int AW    = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;
  localparam int SUM_W = PIX_W + 12;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_LINE);
  localparam logic [LEN_W-1:0] TWO     = LEN_W'(2);
  localparam logic [LEN_W-1:0] THREE   = LEN_W'(3);
  localparam logic signed [SUM_W-1:0] PIX_MAX = SUM_W'((1 << PIX_W) - 1);

  // Handshake: a beat transfers on valid && ready; the single output register
  // frees when empty or draining, so s_ready = !m_valid || m_ready.
  logic accept, sof_acc;
  assign s_ready = !m_valid || m_ready;
  assign accept  = s_valid && s_ready;
  assign sof_acc = accept && s_sof;

  logic [1:0]        mode_q;
  logic [71:0]       kernel_q;
  logic [3:0]        norm_q;
  logic [PIX_W-1:0]  thresh_q;
  logic [LEN_W-1:0]  len_q, col_q, row_q;

  // The sof pixel itself uses the freshly presented configuration.
  logic [1:0]        mode_e;
  logic [71:0]       kernel_e;
  logic [3:0]        norm_e;
  logic [PIX_W-1:0]  thresh_e;
  logic [LEN_W-1:0]  len_raw, len_e, col_e, row_e;
  logic [AW-1:0]     addr;

  assign mode_e   = sof_acc ? mode       : mode_q;
  assign kernel_e = sof_acc ? kernel     : kernel_q;
  assign norm_e   = sof_acc ? norm_shift : norm_q;
  assign thresh_e = sof_acc ? thresh     : thresh_q;
  assign len_raw  = sof_acc ? line_len   : len_q;
  assign len_e    = (len_raw == '0 || len_raw > MAX_LEN) ? MAX_LEN : len_raw;
  assign col_e    = sof_acc ? '0 : col_q;
  assign row_e    = sof_acc ? '0 : row_q;
  assign addr     = col_e[AW-1:0];

  logic [PIX_W-1:0] lb1 [MAX_LINE];
  logic [PIX_W-1:0] lb2 [MAX_LINE];
  logic [PIX_W-1:0] cur [3];
  logic [PIX_W-1:0] win_l [3];
  logic [PIX_W-1:0] win_m [3];

  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[addr] <= s_pixel;
      lb2[addr] <= lb1[addr];
    end
  end

  assign cur[0] = lb2[addr];
  assign cur[1] = lb1[addr];
  assign cur[2] = s_pixel;

  logic signed [SUM_W-1:0] sum, shifted, px_s, tap_s;
  logic [PIX_W-1:0]        px, conv_pix, res;
  logic [7:0]              tap;
  logic                    conv_sat, produce;

  always_comb begin
    sum   = '0;
    px    = '0;
    tap   = '0;
    px_s  = '0;
    tap_s = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        px    = (c == 0) ? win_l[r] : (c == 1) ? win_m[r] : cur[r];
        tap   = kernel_e[8*(3*r+c) +: 8];
        px_s  = SUM_W'({1'b0, px});
        tap_s = {{(SUM_W-8){tap[7]}}, tap};
        sum   = sum + px_s * tap_s;
      end
    end
    shifted  = sum >>> norm_e;
    conv_sat = 1'b0;
    if (shifted < 0) begin
      conv_pix = '0;
      conv_sat = 1'b1;
    end else if (shifted > PIX_MAX) begin
      conv_pix = '1;
      conv_sat = 1'b1;
    end else begin
      conv_pix = shifted[PIX_W-1:0];
    end
  end

  always_comb begin
    case (mode_e)
      2'b00:   res = s_pixel;
      2'b01:   res = ~s_pixel;
      2'b10:   res = conv_pix;
      default: res = (s_pixel >= thresh_e) ? '1 : '0;
    endcase
    produce = (mode_e != 2'b10) || (row_e >= TWO && col_e >= TWO && len_e >= THREE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid  <= 1'b0;
      m_pixel  <= '0;
      busy     <= 1'b0;
      mode_q   <= 2'b00;
      kernel_q <= '0;
      norm_q   <= '0;
      thresh_q <= '0;
      len_q    <= MAX_LEN;
      col_q    <= '0;
      row_q    <= '0;
      for (int r = 0; r < 3; r++) begin
        win_l[r] <= '0;
        win_m[r] <= '0;
      end
    end else begin
      if (m_ready) m_valid <= 1'b0;
      if (accept && produce) begin
        m_valid <= 1'b1;
        m_pixel <= res;
      end
      if (accept) begin
        if (col_e == len_e - 1'b1) begin
          col_q <= '0;
          row_q <= (row_e == '1) ? row_e : row_e + 1'b1;
        end else begin
          col_q <= col_e + 1'b1;
          row_q <= row_e;
        end
        for (int r = 0; r < 3; r++) begin
          win_l[r] <= win_m[r];
          win_m[r] <= cur[r];
        end
      end
      if (sof_acc) begin
        busy     <= 1'b1;
        mode_q   <= mode;
        kernel_q <= kernel;
        norm_q   <= norm_shift;
        thresh_q <= thresh;
        len_q    <= len_e;
      end
    end
  end

`ifdef PIX_PROC_SAT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt <= '0;
    end else if (sof_acc) begin
      sat_cnt <= '0;
    end else if (accept && produce && mode_e == 2'b10 && conv_sat && sat_cnt != 16'hFFFF) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_proc_stream.sv
// Directed bench for pixel_proc_stream: checks outputs cycle by cycle and against an expected queue.
module tb_pixel_proc_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_pixel = '0;
  logic        s_sof = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [1:0]  mode = 2'b00;
  logic [71:0] kernel = '0;
  logic [3:0]  norm_shift = '0;
  logic [7:0]  thresh = '0;
  logic [10:0] line_len = '0;
  logic [7:0]  m_pixel;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        busy;
`ifdef PIX_PROC_SAT_CNT_EN
  logic [15:0] sat_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  pixel_proc_stream #(.PIX_W(8), .MAX_LINE(1024), .LEN_W(11)) dut (
    .clk(clk), .rst(rst), .s_pixel(s_pixel), .s_sof(s_sof), .s_valid(s_valid),
    .s_ready(s_ready), .mode(mode), .kernel(kernel), .norm_shift(norm_shift),
    .thresh(thresh), .line_len(line_len), .m_pixel(m_pixel), .m_valid(m_valid),
    .m_ready(m_ready), .busy(busy)
`ifdef PIX_PROC_SAT_CNT_EN
    , .sat_cnt(sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Transfers are stable between edges; the negedge sees what the next posedge retires.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) got_q.push_back(m_pixel);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic send1(input logic [7:0] pix, input logic sof);
    s_pixel = pix;
    s_sof   = sof;
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  // kind 1: bypass pixel check each beat; kind 2: conv m_valid only at row>=2, col>=2
  task automatic stream(input int w, input int h, input logic [7:0] base, input bit inc,
                        input int kind);
    logic [7:0] pix;
    for (int idx = 0; idx < w * h; idx++) begin
      pix = inc ? 8'(base + idx) : base;
      send1(pix, idx == 0);
      if (kind == 1) begin
        chk("byp_vld", m_valid, 1);
        chk("byp_pix", m_pixel, pix);
      end else if (kind == 2) begin
        chk("conv_vld", m_valid, ((idx / w) >= 2 && (idx % w) >= 2) ? 1 : 0);
      end
    end
  endtask

  task automatic drain();
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("drain_vld", m_valid, 0);
  endtask

  task automatic compare_q(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, "_data"}, got_q[i], exp_q[i]);
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_pixel", m_pixel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s_ready", s_ready, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_busy", busy, 0);

    // Bypass 4x4 ramp, back to back
    mode = 2'b00; line_len = 11'd4;
    stream(4, 4, 8'd0, 1'b1, 1);
    chk("byp_busy", busy, 1);
    drain();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    compare_q("byp");

    // Invert with a 5-cycle stall on the first output
    mode = 2'b01; m_ready = 1'b0;
    send1(8'h3C, 1'b1);
    chk("inv_vld", m_valid, 1);
    chk("inv_pix", m_pixel, 8'hC3);
    chk("inv_ready_drop", s_ready, 0);
    s_pixel = 8'h11; s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("stall_pix", m_pixel, 8'hC3);
      chk("stall_ready", s_ready, 0);
    end
    m_ready = 1'b1;
    send1(8'h11, 1'b0);
    chk("inv_pix2", m_pixel, 8'hEE);
    send1(8'h22, 1'b0);
    chk("inv_pix3", m_pixel, 8'hDD);
    drain();
    exp_q.push_back(8'hC3); exp_q.push_back(8'hEE); exp_q.push_back(8'hDD);
    compare_q("inv");

    // Convolution 5x5 of 10, box kernel: 9 x 90
    mode = 2'b10; line_len = 11'd5; kernel = {9{8'h01}}; norm_shift = 4'd0;
    stream(5, 5, 8'd10, 1'b0, 2);
    drain();
    for (int i = 0; i < 9; i++) exp_q.push_back(8'd90);
    compare_q("conv_box");

    // Centre tap -1 on 200: clamps low
    kernel = 72'h00_00_00_00_FF_00_00_00_00;
    stream(5, 5, 8'd200, 1'b0, 2);
    drain();
    for (int i = 0; i < 9; i++) exp_q.push_back(8'd0);
    compare_q("conv_neg");
`ifdef PIX_PROC_SAT_CNT_EN
    chk("sat_cnt_low", sat_cnt, 9);
`endif

    // All taps 0x7F on 200: clamps high
    kernel = {9{8'h7F}};
    stream(5, 5, 8'd200, 1'b0, 2);
    drain();
    for (int i = 0; i < 9; i++) exp_q.push_back(8'd255);
    compare_q("conv_high");
`ifdef PIX_PROC_SAT_CNT_EN
    chk("sat_cnt_high", sat_cnt, 9);
`endif

    // Box kernel with shift 2: 90 >>> 2 = 22
    kernel = {9{8'h01}}; norm_shift = 4'd2;
    stream(5, 5, 8'd10, 1'b0, 2);
    drain();
    for (int i = 0; i < 9; i++) exp_q.push_back(8'd22);
    compare_q("conv_shift");

    // Tap ordering: 3x3 of 1..9 with taps 1..9, sum 285 >>> 1 = 142
    line_len = 11'd3; norm_shift = 4'd1;
    kernel = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    stream(3, 3, 8'd1, 1'b1, 2);
    drain();
    exp_q.push_back(8'd142);
    compare_q("conv_order");

    // Line length 2: convolution never emits
    line_len = 11'd2; kernel = {9{8'h01}}; norm_shift = 4'd0;
    stream(2, 4, 8'd10, 1'b0, 2);
    drain();
    compare_q("conv_short");

    // Threshold 128, mode change mid-frame ignored
    mode = 2'b11; thresh = 8'd128; line_len = 11'd4;
    send1(8'd127, 1'b1);
    chk("thr_127", m_pixel, 8'h00);
    mode = 2'b01; thresh = 8'd0;
    send1(8'd128, 1'b0);
    chk("thr_128", m_pixel, 8'hFF);
    send1(8'd255, 1'b0);
    chk("thr_255", m_pixel, 8'hFF);
    mode = 2'b00;
    send1(8'd5, 1'b1);
    chk("new_sof_bypass", m_pixel, 8'd5);
    drain();
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'hFF); exp_q.push_back(8'd5);
    compare_q("thr");

    // Reset while a conv result is pending
    mode = 2'b10; line_len = 11'd3; kernel = {9{8'h01}};
    stream(3, 3, 8'd10, 1'b0, 2);
    m_ready = 1'b0;
    chk("pend_pix", m_pixel, 8'd90);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_vld", m_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pix", m_pixel, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_ready = 1'b1;
    got_q.delete();
    stream(3, 3, 8'd20, 1'b0, 2);
    drain();
    exp_q.push_back(8'd180);
    compare_q("post_rst");
    chk("post_rst_busy", busy, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
